// File: rtl/rr_arb_pkg.sv
// Shared types and limits for the round-robin arbiter.
package rr_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_st_t;

  localparam int N_MIN = 2;
  localparam int N_MAX = 16;

endpackage

// File: rtl/rr_arb_pick.sv
// Rotating priority pick: first set bit of vec at or above ptr, wrapping.
import rr_arb_pkg::*;

module rr_pick #(
  parameter int N    = 3,
  parameter int IDXW = $clog2(N)
) (
  input  logic [N-1:0]    vec,
  input  logic [IDXW-1:0] ptr,
  output logic [N-1:0]    onehot,
  output logic [IDXW-1:0] idx
);

  localparam logic [IDXW:0] NV = (IDXW+1)'(N);

  logic [N-1:0]    rot;
  logic [IDXW-1:0] off;
  logic [IDXW:0]   sum;
  logic            found;

  // Bit j of rot is requester (ptr + j) mod N.
  assign rot = N'({vec, vec} >> ptr);

  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int j = 0; j < N; j++) begin
      if (!found && rot[j]) begin
        found = 1'b1;
        off   = j[IDXW-1:0];
      end
    end
  end

  always_comb begin
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= NV) idx = IDXW'(sum - NV);
    else           idx = sum[IDXW-1:0];
    onehot = '0;
    if (found) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_arb.sv
// Round-robin arbiter with a registered one-hot grant held until accepted.
import rr_arb_pkg::*;

module rr_arb #(
  parameter  int N    = 3,
  localparam int IDXW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            out_ready,
  output logic [N-1:0]    gnt,
  output logic            gnt_vld,
  output logic [IDXW-1:0] gnt_idx,
  output logic [N-1:0]    rdy
);

  if (N < N_MIN || N > N_MAX) begin : g_bad_n
    $error("rr_arb: N out of range");
  end

  arb_st_t         st;
  logic [IDXW-1:0] ptr;
  logic [IDXW-1:0] ptr_nxt;
  logic [IDXW-1:0] pick_ptr;
  logic [N-1:0]    cand;
  logic [N-1:0]    p_oh;
  logic [IDXW-1:0] p_idx;

  assign ptr_nxt = (gnt_idx == IDXW'(N-1)) ? '0 : gnt_idx + 1'b1;

  // Busy picks use the post-transfer pointer and skip the served requester.
  assign pick_ptr = (st == ARB_BUSY) ? ptr_nxt : ptr;
  assign cand     = (st == ARB_BUSY) ? (req & ~gnt) : req;

  rr_pick #(.N(N), .IDXW(IDXW)) u_pick (
    .vec    (cand),
    .ptr    (pick_ptr),
    .onehot (p_oh),
    .idx    (p_idx)
  );

  assign rdy = gnt & {N{out_ready}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= ARB_IDLE;
      ptr     <= '0;
      gnt     <= '0;
      gnt_vld <= 1'b0;
      gnt_idx <= '0;
    end else begin
      unique case (st)
        ARB_IDLE: begin
          if (|req) begin
            gnt     <= p_oh;
            gnt_idx <= p_idx;
            gnt_vld <= 1'b1;
            st      <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (out_ready) begin
            ptr <= ptr_nxt;
            if (|cand) begin
              gnt     <= p_oh;
              gnt_idx <= p_idx;
              gnt_vld <= 1'b1;
            end else begin
              gnt     <= '0;
              gnt_idx <= '0;
              gnt_vld <= 1'b0;
              st      <= ARB_IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arb.sv
// Directed scoreboard bench for rr_arb with N=3.
module tb_rr_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req;
  logic       out_ready;
  logic [2:0] gnt;
  logic       gnt_vld;
  logic [1:0] gnt_idx;
  logic [2:0] rdy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0] g;
    logic [1:0] i;
    logic [2:0] r;
    bit         cp;
    logic [1:0] p;
    int         n;
  } exp_t;

  exp_t q[$];
  int   stepno = 0;

  rr_arb #(.N(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .out_ready (out_ready),
    .gnt       (gnt),
    .gnt_vld   (gnt_vld),
    .gnt_idx   (gnt_idx),
    .rdy       (rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int n,
                     input logic [3:0] act, input logic [3:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s step=%0d got=%0h want=%0h", nm, n, act, want);
    end
  endtask

  // Drive one cycle of inputs just after the edge and queue the outputs
  // expected for that cycle; a pulse releases rst after the check point.
  task automatic step(input logic r, input bit pulse, input logic [2:0] rq,
                      input logic o, input logic [2:0] eg,
                      input logic [1:0] ei, input logic [2:0] er,
                      input bit cp, input logic [1:0] ep);
    exp_t e;
    @(posedge clk);
    #1;
    rst       = r;
    req       = rq;
    out_ready = o;
    e.g  = eg;
    e.i  = ei;
    e.r  = er;
    e.cp = cp;
    e.p  = ep;
    e.n  = stepno;
    stepno++;
    q.push_back(e);
    if (pulse) begin
      #6;
      rst = 1'b0;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("gnt", e.n, {1'b0, gnt}, {1'b0, e.g});
        chk("gnt_idx", e.n, {2'b0, gnt_idx}, {2'b0, e.i});
        chk("gnt_vld", e.n, {3'b0, gnt_vld}, {3'b0, |e.g});
        chk("rdy", e.n, {1'b0, rdy}, {1'b0, e.r});
        chk("onehot0", e.n, {3'b0, $onehot0(gnt)}, 4'd1);
        if (e.cp) chk("ptr", e.n, {2'b0, dut.ptr}, {2'b0, e.p});
      end
    end
  end

  initial begin
    int wait_cnt;
    rst       = 1'b1;
    req       = 3'b111;
    out_ready = 1'b0;
    // reset held with all requests pending
    step(1, 0, 3'b111, 0, 3'b000, 0, 3'b000, 1, 0);
    step(1, 0, 3'b111, 0, 3'b000, 0, 3'b000, 0, 0);
    step(1, 0, 3'b111, 0, 3'b000, 0, 3'b000, 0, 0);
    step(0, 0, 3'b111, 0, 3'b000, 0, 3'b000, 1, 0);
    // continuous rotation
    step(0, 0, 3'b111, 1, 3'b001, 0, 3'b001, 0, 0);
    step(0, 0, 3'b111, 1, 3'b010, 1, 3'b010, 1, 1);
    step(0, 0, 3'b111, 1, 3'b100, 2, 3'b100, 1, 2);
    step(0, 0, 3'b111, 1, 3'b001, 0, 3'b001, 1, 0);
    step(0, 0, 3'b000, 1, 3'b010, 1, 3'b010, 1, 1);
    step(0, 0, 3'b000, 0, 3'b000, 0, 3'b000, 1, 2);
    // backpressure on a one-cycle request
    step(0, 0, 3'b100, 0, 3'b000, 0, 3'b000, 0, 0);
    step(0, 0, 3'b000, 0, 3'b100, 2, 3'b000, 0, 0);
    step(0, 0, 3'b000, 0, 3'b100, 2, 3'b000, 0, 0);
    step(0, 0, 3'b000, 0, 3'b100, 2, 3'b000, 0, 0);
    step(0, 0, 3'b000, 1, 3'b100, 2, 3'b100, 0, 0);
    step(0, 0, 3'b000, 0, 3'b000, 0, 3'b000, 1, 0);
    // solo re-request bubbles
    step(0, 0, 3'b010, 1, 3'b000, 0, 3'b000, 0, 0);
    step(0, 0, 3'b010, 1, 3'b010, 1, 3'b010, 0, 0);
    step(0, 0, 3'b010, 1, 3'b000, 0, 3'b000, 1, 2);
    step(0, 0, 3'b010, 1, 3'b010, 1, 3'b010, 0, 0);
    step(0, 0, 3'b000, 1, 3'b000, 0, 3'b000, 1, 2);
    // grant stability while req changes
    step(0, 0, 3'b001, 0, 3'b000, 0, 3'b000, 0, 0);
    step(0, 0, 3'b110, 0, 3'b001, 0, 3'b000, 0, 0);
    step(0, 0, 3'b110, 0, 3'b001, 0, 3'b000, 0, 0);
    step(0, 0, 3'b110, 1, 3'b001, 0, 3'b001, 0, 0);
    step(0, 0, 3'b110, 1, 3'b010, 1, 3'b010, 1, 1);
    step(0, 0, 3'b000, 1, 3'b100, 2, 3'b100, 1, 2);
    step(0, 0, 3'b000, 0, 3'b000, 0, 3'b000, 1, 0);
    // async reset pulse mid-grant
    step(0, 0, 3'b011, 1, 3'b000, 0, 3'b000, 0, 0);
    step(0, 0, 3'b011, 1, 3'b001, 0, 3'b001, 0, 0);
    step(0, 0, 3'b011, 0, 3'b010, 1, 3'b000, 1, 1);
    step(1, 1, 3'b011, 0, 3'b000, 0, 3'b000, 1, 0);
    step(0, 0, 3'b011, 1, 3'b001, 0, 3'b001, 1, 0);
    step(0, 0, 3'b000, 1, 3'b010, 1, 3'b010, 1, 1);
    step(0, 0, 3'b000, 0, 3'b000, 0, 3'b000, 1, 2);
    wait_cnt = 0;
    while (q.size() > 0 && wait_cnt < 5) begin
      @(posedge clk);
      wait_cnt++;
    end
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
